nec_ir_rx: RTL and testbench

- Parametrised NEC infrared remote receiver: successor to the fixed-timing single-buffer IR decoder.
- Decodes 32-bit NEC frames and repeat codes from the demodulated IR pin, with timing defined in microseconds via a clock prescaler.
- Applies configurable integrity checks, queues results in a show-ahead FIFO, and reports overflow and frame errors.
- Sits between the IR receiver pin and the media-control bus/CPU reader.

---
 rtl/nec_ir_rx.sv | 277 +++++++++++++++++++++++++++
 tb/tb_nec_ir_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_rx.sv
// NEC infrared remote receiver: microsecond-timed pulse decoder with integrity checks,
// repeat-code handling, a show-ahead result FIFO and sticky overflow / error reporting.
module nec_ir_rx #(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CHECK_CMD  = 1,
    parameter int unsigned CHECK_ADDR = 0,
    parameter int unsigned REPEAT_EN  = 1,
    parameter int unsigned TIMEOUT_US = 12000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iIRDA,
    input  logic        iREAD,
    input  logic        iCLR_ERR,
    output logic        oDATA_READY,
    output logic [31:0] oDATA,
    output logic        oREPEAT,
    output logic        oOVERFLOW,
    output logic [7:0]  oERR_CNT
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [13:0] CNT_MAX     = 14'h3FFF;
    localparam logic [13:0] TIMEOUT_CNT = 14'(TIMEOUT_US);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LEAD_LOW  = 3'd1,
        S_LEAD_HIGH = 3'd2,
        S_BIT_LOW   = 3'd3,
        S_BIT_HIGH  = 3'd4,
        S_STOP      = 3'd5
    } state_t;

    function automatic logic in_rng(input logic [13:0] v, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Input synchroniser and registered edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic rise_q, fall_q;

    // Microsecond prescaler and pulse-length counter
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic [13:0]      pulse_q, pulse_d;

    // Decoder state
    state_t      state_q, state_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [31:0] shift_q, shift_d;
    logic        rpt_q, rpt_d;
    logic        frame_ok, frame_err;

    // Completion stage
    logic [31:0] last_q, last_d;
    logic        last_vld_q, last_vld_d;
    logic        push_q, push_d;
    logic [31:0] push_data_q, push_data_d;
    logic        push_rpt_q, push_rpt_d;
    logic        err_evt;
    logic        cmd_ok, addr_ok;

    // FIFO and status
    logic [32:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           empty, full, pop, do_push, ovf_evt;
    logic [32:0]    head;
    logic           ovf_q, ovf_d;
    logic [7:0]     err_q, err_d;

    assign tick = (pre_q == PRE_W'(CLK_DIV - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        pulse_d = pulse_q;
        if (rise_q || fall_q) begin
            pulse_d = '0;
        end else if (tick && (pulse_q != CNT_MAX)) begin
            pulse_d = pulse_q + 14'd1;
        end
    end

    // Edges take priority over the timeout; pulse_q holds the length of the level just ended.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rpt_d     = rpt_q;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if ((state_q != S_IDLE) && !rise_q && !fall_q && (pulse_q >= TIMEOUT_CNT)) begin
            state_d   = S_IDLE;
            frame_err = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall_q) state_d = S_LEAD_LOW;
                end
                S_LEAD_LOW: begin
                    if (rise_q) begin
                        if (in_rng(pulse_q, 14'd8000, 14'd10000)) begin
                            state_d = S_LEAD_HIGH;
                        end else begin
                            state_d   = S_IDLE;
                            frame_err = 1'b1;
                        end
                    end
                end
                S_LEAD_HIGH: begin
                    if (fall_q) begin
                        if (in_rng(pulse_q, 14'd4000, 14'd5000)) begin
                            state_d   = S_BIT_LOW;
                            bit_idx_d = 5'd0;
                            rpt_d     = 1'b0;
                        end else if (in_rng(pulse_q, 14'd1800, 14'd2700)) begin
                            state_d = S_STOP;
                            rpt_d   = 1'b1;
                        end else begin
                            state_d   = S_IDLE;
                            frame_err = 1'b1;
                        end
                    end
                end
                S_BIT_LOW: begin
                    if (rise_q) begin
                        if (in_rng(pulse_q, 14'd300, 14'd800)) begin
                            state_d = S_BIT_HIGH;
                        end else begin
                            state_d   = S_IDLE;
                            frame_err = 1'b1;
                        end
                    end
                end
                S_BIT_HIGH: begin
                    if (fall_q) begin
                        if (in_rng(pulse_q, 14'd300, 14'd800) ||
                            in_rng(pulse_q, 14'd1300, 14'd2000)) begin
                            shift_d[bit_idx_q] = (pulse_q >= 14'd1300);
                            bit_idx_d          = bit_idx_q + 5'd1;
                            state_d            = (bit_idx_q == 5'd31) ? S_STOP : S_BIT_LOW;
                        end else begin
                            state_d   = S_IDLE;
                            frame_err = 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (rise_q) begin
                        state_d = S_IDLE;
                        if (in_rng(pulse_q, 14'd300, 14'd800)) begin
                            frame_ok = 1'b1;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cmd_ok  = (CHECK_CMD == 0)  || (shift_q[31:24] == ~shift_q[23:16]);
    assign addr_ok = (CHECK_ADDR == 0) || (shift_q[15:8] == ~shift_q[7:0]);

    always_comb begin
        push_d      = 1'b0;
        push_data_d = push_data_q;
        push_rpt_d  = push_rpt_q;
        last_d      = last_q;
        last_vld_d  = last_vld_q;
        err_evt     = frame_err;
        if (frame_ok) begin
            if (rpt_q) begin
                if ((REPEAT_EN != 0) && last_vld_q) begin
                    push_d      = 1'b1;
                    push_data_d = last_q;
                    push_rpt_d  = 1'b1;
                end
            end else if (cmd_ok && addr_ok) begin
                push_d      = 1'b1;
                push_data_d = shift_q;
                push_rpt_d  = 1'b0;
                last_d      = shift_q;
                last_vld_d  = 1'b1;
            end else begin
                err_evt = 1'b1;
            end
        end
    end

    // iREAD pops the head only while oDATA_READY is high; a push into a full FIFO is
    // accepted only if the same cycle also pops.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop     = iREAD && !empty;
    assign do_push = push_q && (!full || pop);
    assign ovf_evt = push_q && full && !pop;
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d    = (ovf_q && !iCLR_ERR) || ovf_evt;
        err_d    = err_q;
        if (iCLR_ERR) begin
            err_d = err_evt ? 8'd1 : 8'd0;
        end else if (err_evt && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            pre_q       <= '0;
            pulse_q     <= '0;
            state_q     <= S_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rpt_q       <= 1'b0;
            last_q      <= '0;
            last_vld_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            push_rpt_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            err_q       <= '0;
        end else begin
            sync1_q     <= iIRDA;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            rise_q      <= sync2_q && !sync3_q;
            fall_q      <= !sync2_q && sync3_q;
            pre_q       <= pre_d;
            pulse_q     <= pulse_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rpt_q       <= rpt_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            push_rpt_q  <= push_rpt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: the outputs are gated by the empty flag.
    always_ff @(posedge iCLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {push_rpt_q, push_data_q};
        end
    end

    assign oDATA_READY = !empty;
    assign oDATA       = empty ? 32'd0 : head[31:0];
    assign oREPEAT     = !empty && head[32];
    assign oOVERFLOW   = ovf_q;
    assign oERR_CNT    = err_q;

endmodule

// File: tb/tb_nec_ir_rx.sv
// Bench for nec_ir_rx: drives NEC frames at 1 tick per clock and checks the decoded
// FIFO contents against an expected queue.
module tb_nec_ir_rx;

    localparam int DIV     = 1;
    localparam int LEAD_LO = 9000;
    localparam int LEAD_HI = 4500;
    localparam int RPT_HI  = 2250;
    localparam int BIT_LO  = 560;
    localparam int ZERO_HI = 560;
    localparam int ONE_HI  = 1690;
    localparam int STOP_LO = 560;

    localparam logic [31:0] CODE_A   = 32'hBA45FF00;
    localparam logic [31:0] CODE_BAD = 32'hBB45FF00;
    localparam logic [31:0] CODE_C   = 32'hFF000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ir_line = 1'b1;
    logic route_b = 1'b0;
    logic irda_b;
    logic rd_a = 1'b0, clr_a = 1'b0, rd_b = 1'b0, clr_b = 1'b0;

    logic        a_ready, a_rpt, a_ovf;
    logic [31:0] a_data;
    logic [7:0]  a_err;
    logic        b_ready, b_rpt, b_ovf;
    logic [31:0] b_data;
    logic [7:0]  b_err;

    logic [32:0] exp_q[$];
    int total = 0;
    int bad = 0;

    assign irda_b = route_b ? ir_line : 1'b1;

    always #5 clk = ~clk;

    nec_ir_rx #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .CHECK_CMD(1), .CHECK_ADDR(0),
                .REPEAT_EN(1), .TIMEOUT_US(12000)) dut (
        .iCLK(clk), .iRST_n(rst_n), .iIRDA(ir_line), .iREAD(rd_a), .iCLR_ERR(clr_a),
        .oDATA_READY(a_ready), .oDATA(a_data), .oREPEAT(a_rpt), .oOVERFLOW(a_ovf),
        .oERR_CNT(a_err)
    );

    nec_ir_rx #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .CHECK_CMD(0), .CHECK_ADDR(0),
                .REPEAT_EN(1), .TIMEOUT_US(12000)) dut_nc (
        .iCLK(clk), .iRST_n(rst_n), .iIRDA(irda_b), .iREAD(rd_b), .iCLR_ERR(clr_b),
        .oDATA_READY(b_ready), .oDATA(b_data), .oREPEAT(b_rpt), .oOVERFLOW(b_ovf),
        .oERR_CNT(b_err)
    );

    task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic hold(input logic lvl, input int us);
        ir_line = lvl;
        repeat (us * DIV) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, BIT_LO);
            hold(1'b1, code[i] ? ONE_HI : ZERO_HI);
        end
    endtask

    task automatic send_frame(input logic [31:0] code);
        hold(1'b0, LEAD_LO);
        hold(1'b1, LEAD_HI);
        send_bits(code, 32);
        hold(1'b0, STOP_LO);
        ir_line = 1'b1;
    endtask

    task automatic send_repeat();
        hold(1'b0, LEAD_LO);
        hold(1'b1, RPT_HI);
        hold(1'b0, STOP_LO);
        ir_line = 1'b1;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic read_entry(input string tag);
        logic [32:0] want;
        check_val({tag, "_rdy"}, 40'(a_ready), 40'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
        check_val(tag, {7'd0, a_rpt, a_data}, {7'd0, want});
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check_val({tag, "_rdy"}, 40'(a_ready), 40'd0);
        check_val({tag, "_data"}, {7'd0, a_rpt, a_data}, 40'd0);
    endtask

    initial begin
        logic [32:0] want;

        repeat (3) @(negedge clk);
        check_empty("rst");
        check_val("rst_ovf", 40'(a_ovf), 40'd0);
        check_val("rst_err", 40'(a_err), 40'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Repeat code with no prior valid frame is discarded silently
        send_repeat();
        settle();
        check_empty("rpt_novalid");
        check_val("rpt_novalid_err", 40'(a_err), 40'd0);

        // Good frame: latency to oDATA_READY, contents, pop to empty
        send_frame(CODE_A);
        exp_q.push_back({1'b0, CODE_A});
        repeat (4) @(negedge clk);
        check_val("lat4_rdy", 40'(a_ready), 40'd0);
        @(negedge clk);
        check_val("lat5_rdy", 40'(a_ready), 40'd1);
        read_entry("frame_a");
        check_empty("frame_a_pop");

        // Repeat re-queues last valid code with the repeat flag
        send_repeat();
        exp_q.push_back({1'b1, CODE_A});
        settle();
        read_entry("rpt_a");
        check_empty("rpt_a_pop");

        // Bad inverse command byte: rejected with checks on, accepted with checks off
        route_b = 1'b1;
        send_frame(CODE_BAD);
        settle();
        route_b = 1'b0;
        check_empty("bad_cmd");
        check_val("bad_cmd_err", 40'(a_err), 40'd1);
        check_val("nc_rdy", 40'(b_ready), 40'd1);
        check_val("nc_data", {7'd0, b_rpt, b_data}, {8'd0, CODE_BAD});
        check_val("nc_err", 40'(b_err), 40'd0);

        // Fill the FIFO with repeats; the fifth push overflows
        for (int i = 0; i < 5; i++) begin
            send_repeat();
            settle();
            if (exp_q.size() < 4) exp_q.push_back({1'b1, CODE_A});
            check_val($sformatf("fill%0d_ovf", i), 40'(a_ovf), (i == 4) ? 40'd1 : 40'd0);
        end
        check_val("fill_err", 40'(a_err), 40'd1);

        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check_val("clr_ovf", 40'(a_ovf), 40'd0);
        check_val("clr_err", 40'(a_err), 40'd0);

        // Pop in the same cycle as a push into a full FIFO
        send_repeat();
        repeat (4) @(negedge clk);
        want = exp_q.pop_front();
        check_val("pushpop_head", {7'd0, a_rpt, a_data}, {7'd0, want});
        rd_a = 1'b1;
        exp_q.push_back({1'b1, CODE_A});
        @(negedge clk);
        rd_a = 1'b0;
        settle();
        check_val("pushpop_ovf", 40'(a_ovf), 40'd0);
        for (int i = 0; i < 4; i++) read_entry($sformatf("drain%0d", i));
        check_empty("drain_end");

        // Line held low after bit 10 times out
        hold(1'b0, LEAD_LO);
        hold(1'b1, LEAD_HI);
        send_bits(CODE_A, 11);
        hold(1'b0, 13000);
        ir_line = 1'b1;
        settle();
        check_empty("timeout");
        check_val("timeout_err", 40'(a_err), 40'd1);

        // Decoder recovers after the timeout
        send_repeat();
        exp_q.push_back({1'b1, CODE_A});
        settle();
        check_val("post_to_rdy", 40'(a_ready), 40'd1);

        // Reset in the middle of bit 20 clears everything without an error
        hold(1'b0, LEAD_LO);
        hold(1'b1, LEAD_HI);
        send_bits(CODE_A, 20);
        hold(1'b0, 200);
        rst_n = 1'b0;
        ir_line = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_empty("midrst");
        check_val("midrst_ovf", 40'(a_ovf), 40'd0);
        check_val("midrst_err", 40'(a_err), 40'd0);
        repeat (5) @(negedge clk);

        send_frame(CODE_C);
        exp_q.push_back({1'b0, CODE_C});
        settle();
        read_entry("frame_c");
        check_empty("frame_c_pop");
        check_val("final_err", 40'(a_err), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
